// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - round-robin io bus arbiter with a 2-stage grant/issue/response pipeline
// Define IO_BUS_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration with no rotation pointer.
module io_bus_arbiter #(
    parameter int NUM_REQUESTERS = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_REQUESTERS-1:0]                   req_valid,
    input  logic [NUM_REQUESTERS-1:0]                   req_store,
    input  logic [NUM_REQUESTERS-1:0][ADDR_WIDTH-1:0]   req_address,
    input  logic [NUM_REQUESTERS-1:0][DATA_WIDTH-1:0]   req_write_data,
    output logic [NUM_REQUESTERS-1:0]                   req_ready,
    output logic [NUM_REQUESTERS-1:0]                   rsp_valid,
    output logic [DATA_WIDTH-1:0]                       rsp_read_data,
    output logic                                        io_write_en,
    output logic                                        io_read_en,
    output logic [ADDR_WIDTH-1:0]                       io_address,
    output logic [DATA_WIDTH-1:0]                       io_write_data,
    input  logic [DATA_WIDTH-1:0]                       io_read_data
);
    localparam int PTR_W = $clog2(NUM_REQUESTERS);

    logic [NUM_REQUESTERS-1:0] grant;
    logic [PTR_W-1:0]          grant_idx;
    logic                      found;
    int                        cand;
    logic [NUM_REQUESTERS-1:0] stage1_grant;
    logic                      stage2_load;

`ifndef IO_BUS_ARB_FIXED_PRIORITY_EN
    logic [PTR_W-1:0] rr_ptr;
`endif

    // Search order starts at rr_ptr and wraps; fixed-priority build always starts at 0.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
`ifdef IO_BUS_ARB_FIXED_PRIORITY_EN
            cand = i;
`else
            cand = (int'(rr_ptr) + i) % NUM_REQUESTERS;
`endif
            if (!found && req_valid[PTR_W'(cand)]) begin
                found     = 1'b1;
                grant_idx = PTR_W'(cand);
            end
        end
        if (found && !reset) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign req_ready = grant;

    // Read data is only valid on the bus in the response cycle, so it is passed through.
    assign rsp_read_data = (|rsp_valid && stage2_load) ? io_read_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            io_write_en   <= 1'b0;
            io_read_en    <= 1'b0;
            io_address    <= '0;
            io_write_data <= '0;
            stage1_grant  <= '0;
            rsp_valid     <= '0;
            stage2_load   <= 1'b0;
`ifndef IO_BUS_ARB_FIXED_PRIORITY_EN
            rr_ptr        <= '0;
`endif
        end else begin
            io_write_en  <= |grant && req_store[grant_idx];
            io_read_en   <= |grant && !req_store[grant_idx];
            stage1_grant <= grant;
            rsp_valid    <= stage1_grant;
            stage2_load  <= io_read_en;
            if (|grant) begin
                io_address    <= req_address[grant_idx];
                io_write_data <= req_write_data[grant_idx];
`ifndef IO_BUS_ARB_FIXED_PRIORITY_EN
                rr_ptr        <= (grant_idx == PTR_W'(NUM_REQUESTERS - 1)) ?
                                 '0 : grant_idx + PTR_W'(1);
`endif
            end
        end
    end
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb/tb_io_bus_arbiter.sv - table-driven and sequence checks for io_bus_arbiter
module tb_io_bus_arbiter;
    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       req_valid;
    logic [3:0]       req_store;
    logic [3:0][31:0] req_address;
    logic [3:0][31:0] req_write_data;
    logic [3:0]       req_ready;
    logic [3:0]       rsp_valid;
    logic [31:0]      rsp_read_data;
    logic             io_write_en;
    logic             io_read_en;
    logic [31:0]      io_address;
    logic [31:0]      io_write_data;
    logic [31:0]      io_read_data;

    int passed = 0;
    int total  = 0;

    io_bus_arbiter #(.NUM_REQUESTERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_store(req_store),
        .req_address(req_address), .req_write_data(req_write_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_read_data(rsp_read_data),
        .io_write_en(io_write_en), .io_read_en(io_read_en), .io_address(io_address),
        .io_write_data(io_write_data), .io_read_data(io_read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  store;
        logic [31:0] rdata;
        logic [3:0]  exp_ready;
        logic        exp_wr;
        logic        exp_rd;
        logic [3:0]  exp_rsp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input logic [3:0] v, input logic [3:0] s, input logic [31:0] rd,
                       input logic [3:0] er, input logic ew, input logic erd,
                       input logic [3:0] ersp, input logic [31:0] erdata);
        vec_t t;
        t.valid = v; t.store = s; t.rdata = rd; t.exp_ready = er; t.exp_wr = ew;
        t.exp_rd = erd; t.exp_rsp = ersp; t.exp_rdata = erdata;
        vecs.push_back(t);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid = '0;
        @(negedge clk);
        #1;
        check("reset_ready", 32'(req_ready), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_strobes", {30'h0, io_write_en, io_read_en}, 32'h0);
        check("reset_io_address", io_address, 32'h0);
        check("reset_io_write_data", io_write_data, 32'h0);
        check("reset_rsp_read_data", rsp_read_data, 32'h0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_store = '0;
        io_read_data = '0;
        for (int i = 0; i < 4; i++) begin
            req_address[i]    = 32'h1000 + 32'(i);
            req_write_data[i] = 32'hA000 + 32'(i);
        end

`ifdef IO_BUS_ARB_FIXED_PRIORITY_EN
        add(4'b0000, 4'b0000, 32'h0,  4'b0000, 0, 0, 4'b0000, 32'h0);
        add(4'b1010, 4'b0000, 32'h0,  4'b0010, 0, 0, 4'b0000, 32'h0);
        add(4'b1010, 4'b0000, 32'h0,  4'b0010, 0, 1, 4'b0000, 32'h0);
        add(4'b1010, 4'b0000, 32'h31, 4'b0010, 0, 1, 4'b0010, 32'h31);
        add(4'b1111, 4'b0000, 32'h32, 4'b0001, 0, 1, 4'b0010, 32'h32);
        add(4'b0000, 4'b0000, 32'h33, 4'b0000, 0, 1, 4'b0010, 32'h33);
        add(4'b0000, 4'b0000, 32'h34, 4'b0000, 0, 0, 4'b0001, 32'h34);
        add(4'b0000, 4'b0000, 32'h35, 4'b0000, 0, 0, 4'b0000, 32'h0);
`else
        // Row expectations: strobes reflect the previous row's grant, rsp the one before that.
        add(4'b0000, 4'b0000, 32'h0,  4'b0000, 0, 0, 4'b0000, 32'h0);
        add(4'b1111, 4'b0000, 32'h0,  4'b0001, 0, 0, 4'b0000, 32'h0);
        add(4'b1111, 4'b0000, 32'h0,  4'b0010, 0, 1, 4'b0000, 32'h0);
        add(4'b1111, 4'b0000, 32'hA0, 4'b0100, 0, 1, 4'b0001, 32'hA0);
        add(4'b1111, 4'b0000, 32'hA1, 4'b1000, 0, 1, 4'b0010, 32'hA1);
        add(4'b1111, 4'b0000, 32'hA2, 4'b0001, 0, 1, 4'b0100, 32'hA2);
        add(4'b1111, 4'b0000, 32'hA3, 4'b0010, 0, 1, 4'b1000, 32'hA3);
        add(4'b1111, 4'b0000, 32'hA4, 4'b0100, 0, 1, 4'b0001, 32'hA4);
        add(4'b1111, 4'b0000, 32'hA5, 4'b1000, 0, 1, 4'b0010, 32'hA5);
        add(4'b0000, 4'b0000, 32'hA6, 4'b0000, 0, 1, 4'b0100, 32'hA6);
        add(4'b0000, 4'b0000, 32'hA7, 4'b0000, 0, 0, 4'b1000, 32'hA7);
        add(4'b0000, 4'b0000, 32'hFF, 4'b0000, 0, 0, 4'b0000, 32'h0);
        add(4'b1010, 4'b1010, 32'h0,  4'b0010, 0, 0, 4'b0000, 32'h0);
        add(4'b1010, 4'b1010, 32'h0,  4'b1000, 1, 0, 4'b0000, 32'h0);
        add(4'b0001, 4'b0000, 32'h77, 4'b0001, 1, 0, 4'b0010, 32'h0);
        add(4'b1111, 4'b0000, 32'h78, 4'b0010, 0, 1, 4'b1000, 32'h0);
        add(4'b0000, 4'b0000, 32'h5A, 4'b0000, 0, 1, 4'b0001, 32'h5A);
        add(4'b0000, 4'b0000, 32'h5B, 4'b0000, 0, 0, 4'b0010, 32'h5B);
        add(4'b0000, 4'b0000, 32'h5C, 4'b0000, 0, 0, 4'b0000, 32'h0);
        add(4'b0100, 4'b0000, 32'h0,  4'b0100, 0, 0, 4'b0000, 32'h0);
        add(4'b0100, 4'b0000, 32'h0,  4'b0100, 0, 1, 4'b0000, 32'h0);
        add(4'b0100, 4'b0000, 32'hC1, 4'b0100, 0, 1, 4'b0100, 32'hC1);
        add(4'b0000, 4'b0000, 32'hC2, 4'b0000, 0, 1, 4'b0100, 32'hC2);
        add(4'b0000, 4'b0000, 32'hC3, 4'b0000, 0, 0, 4'b0100, 32'hC3);
        add(4'b0000, 4'b0000, 32'hC4, 4'b0000, 0, 0, 4'b0000, 32'h0);
`endif

        do_reset();
        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            req_valid    = vecs[k].valid;
            req_store    = vecs[k].store;
            io_read_data = vecs[k].rdata;
            #1;
            check($sformatf("row%0d_ready", k), 32'(req_ready), 32'(vecs[k].exp_ready));
            check($sformatf("row%0d_wr", k), 32'(io_write_en), 32'(vecs[k].exp_wr));
            check($sformatf("row%0d_rd", k), 32'(io_read_en), 32'(vecs[k].exp_rd));
            check($sformatf("row%0d_rsp", k), 32'(rsp_valid), 32'(vecs[k].exp_rsp));
            check($sformatf("row%0d_rdata", k), rsp_read_data, vecs[k].exp_rdata);
        end

        // Requester 2 load at 0x100, read data returned on the response cycle.
        do_reset();
        @(negedge clk);
        req_valid = 4'b0100; req_store = 4'b0000; req_address[2] = 32'h100;
        io_read_data = 32'h0;
        #1;
        check("load_ready", 32'(req_ready), 32'h4);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        check("load_rd_en", 32'(io_read_en), 32'h1);
        check("load_wr_en", 32'(io_write_en), 32'h0);
        check("load_address", io_address, 32'h100);
        check("load_rsp_early", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        io_read_data = 32'hDEADBEEF;
        #1;
        check("load_rsp_valid", 32'(rsp_valid), 32'h4);
        check("load_rsp_data", rsp_read_data, 32'hDEADBEEF);
        check("load_rd_en_drop", 32'(io_read_en), 32'h0);

        // Requester 1 store 0x55 to 0x20; store responses carry zero data.
        @(negedge clk);
        req_valid = 4'b0010; req_store = 4'b0010;
        req_address[1] = 32'h20; req_write_data[1] = 32'h55;
        #1;
        check("store_ready", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        check("store_wr_en", 32'(io_write_en), 32'h1);
        check("store_rd_en", 32'(io_read_en), 32'h0);
        check("store_address", io_address, 32'h20);
        check("store_data", io_write_data, 32'h55);
        @(negedge clk);
        io_read_data = 32'h1234;
        #1;
        check("store_rsp_valid", 32'(rsp_valid), 32'h2);
        check("store_rsp_data", rsp_read_data, 32'h0);
        check("hold_address", io_address, 32'h20);
        check("hold_data", io_write_data, 32'h55);
        check("hold_wr_en", 32'(io_write_en), 32'h0);

        // Reset the cycle after a load accept: the in-flight load must vanish.
        @(negedge clk);
        req_valid = 4'b0100; req_store = 4'b0000;
        #1;
        check("abort_ready", 32'(req_ready), 32'h4);
        @(negedge clk);
        reset = 1'b1;
        req_valid = 4'b1111;
        #1;
        check("abort_rd_before_reset", 32'(io_read_en), 32'h1);
        check("abort_ready_in_reset", 32'(req_ready), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        req_valid = 4'b0000;
        #1;
        check("abort_no_rd", 32'(io_read_en), 32'h0);
        check("abort_no_rsp", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        #1;
        check("abort_no_rsp_late", 32'(rsp_valid), 32'h0);
        check("abort_no_strobe_late", {30'h0, io_write_en, io_read_en}, 32'h0);
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        check("abort_ptr_reset", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 4'b0000;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/io_bus_arbiter.md
IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 Parameter NUM_REQUESTERS, default 4, number of requester ports (legal 2..16).
REQ-002 Parameter ADDR_WIDTH, default 32, io_address width.
REQ-003 Parameter DATA_WIDTH, default 32, data width of write/read paths.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 req_valid  input  NUM_REQUESTERS  per-requester request pending.
REQ-008 req_store  input  NUM_REQUESTERS  1 = write, 0 = read.
REQ-009 req_address  input  NUM_REQUESTERS x ADDR_WIDTH  per-requester address.
REQ-010 req_write_data  input  NUM_REQUESTERS x DATA_WIDTH  per-requester write data.
REQ-011 req_ready  output  NUM_REQUESTERS  one-hot grant, combinational, same cycle as accept.
REQ-012 rsp_valid  output  NUM_REQUESTERS  one-hot completion pulse, registered.
REQ-013 rsp_read_data  output  DATA_WIDTH  read result, qualified by rsp_valid.
REQ-014 io_write_en, io_read_en  output  1 each  io bus strobes, mutually exclusive, registered.
REQ-015 io_address  output  ADDR_WIDTH; io_write_data  output  DATA_WIDTH; registered.
REQ-016 io_read_data  input  DATA_WIDTH  valid one cycle after io_read_en.

Function
REQ-017 Cycle N: at most one req_ready bit SHALL assert, and only for a requester with req_valid=1; a transfer occurs when req_valid & req_ready.
REQ-018 Cycle N+1: accepted request SHALL drive io_write_en (store) or io_read_en (load) for exactly one cycle, with io_address/io_write_data captured at N.
REQ-019 Cycle N+2: rsp_valid SHALL pulse for the granted index; rsp_read_data = io_read_data for loads, 0 for stores.
REQ-020 Fully pipelined: one new grant per cycle is allowed; no bubbles with continuous requests.
REQ-021 Round-robin: search starts at pointer rr_ptr, wraps NUM_REQUESTERS-1 -> 0; after a grant to g, rr_ptr = (g+1) mod NUM_REQUESTERS.
REQ-022 No valid requests: no grant, rr_ptr unchanged, io strobes 0 next cycle.
REQ-023 A single continuously valid requester SHALL be granted every cycle.
REQ-024 Requesters may deassert req_valid before grant without side effects; unaccepted requests are never issued.
REQ-025 io_address and io_write_data SHALL hold previous value when no strobe is active.

Reset
REQ-026 On reset: req_ready, rsp_valid, io_write_en, io_read_en = 0; rsp_read_data, io_address, io_write_data = 0; rr_ptr = 0.
REQ-027 Reset asserted mid-transaction SHALL discard in-flight stages; no rsp_valid for them after reset deasserts.
REQ-028 req_ready SHALL be 0 during any cycle with reset=1.

Configuration
REQ-029 Macro IO_BUS_ARB_FIXED_PRIORITY_EN defined: lowest-index valid requester always wins, rr_ptr removed.
REQ-030 Macro undefined: round-robin per REQ-021.

Verification
REQ-031 Reset, then requester 2 load addr 0x100, io_read_data=0xDEADBEEF at N+2 -> io_read_en at N+1, rsp_valid=4'b0100, rsp_read_data=0xDEADBEEF at N+2.
REQ-032 All 4 requesters valid continuously for 8 cycles (round-robin) -> grant order 0,1,2,3,0,1,2,3, one per cycle.
REQ-033 Requester 1 store addr 0x20 data 0x55 -> io_write_en=1, io_address=0x20, io_write_data=0x55 at N+1; rsp_valid=4'b0010, rsp_read_data=0 at N+2.
REQ-034 Grant to 3 then only requester 0 valid -> wrap grants 0, rr_ptr=1.
REQ-035 Reset asserted at N+1 after a load accept -> no io strobe after reset, no rsp_valid, rr_ptr=0.
REQ-036 IO_BUS_ARB_FIXED_PRIORITY_EN defined, requesters 1 and 3 valid 3 cycles -> requester 1 granted all 3 cycles.
